// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Samples the program counter while idle, issues a
// request/acknowledge read to instruction memory, then holds the fetched word
// for decode under a valid/ready handshake. A one-cycle IDLE bubble between
// fetches gives the writeback stage time to update pc.
//
// Ports:
//   clk, rstd            clock, asynchronous active-low reset
//   pc                   current program counter (sampled only in IDLE)
//   flush                redirect; abandons any fetch in progress
//   imem_req/imem_addr   registered read request and word-aligned address
//   imem_ack/imem_rdata  memory response (ignored unless a request is open)
//   ins/ins_pc/ins_valid registered fetched word, its address, and valid
//   ins_ready            decode accepts the instruction
//   pc_plus4             ins_pc + 4 (combinational, wraps modulo 2^32)
//   busy                 state is not IDLE (combinational)
//   fetch_count          accepted handshakes (FETCH_STATS_EN only, else 0)
//   stall_count          REQ cycles without ack (FETCH_STATS_EN only, else 0)
//
// Build option: define FETCH_STATS_EN to generate the saturating performance
// counters; otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_ins;
  logic [31:0] r_ins_pc;
  logic        r_ins_valid;
  logic        w_handshake;

  assign w_handshake = r_ins_valid && ins_ready;

  // State register.
  always_ff @(posedge clk or negedge rstd) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    if (!rstd) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    // NOTE: the default assignment up front keeps this block from inferring a
    // latch on paths that do not change state.
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_next_state = REQ;
        REQ:     if (imem_ack)    w_next_state = HOLD;
        HOLD:    if (w_handshake) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Registered outputs. A flush leaves ins/ins_pc untouched but invalid, and
  // an ack arriving with the flush is simply not captured.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_ADDR;
      r_ins       <= 32'h0;
      r_ins_pc    <= RESET_ADDR;
      r_ins_valid <= 1'b0;
    end else if (flush) begin
      r_imem_req  <= 1'b0;
      r_ins_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // Misaligned low bits are dropped silently.
          r_imem_addr <= {pc[31:2], 2'b00};
          r_imem_req  <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            r_ins       <= imem_rdata;
            r_ins_pc    <= r_imem_addr;
            r_ins_valid <= 1'b1;
            r_imem_req  <= 1'b0;
          end
        end
        HOLD: begin
          if (w_handshake) r_ins_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Combinational outputs from registered state.
  always_comb begin
    busy     = (r_state != IDLE);
    pc_plus4 = r_ins_pc + 32'd4;
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign ins       = r_ins;
  assign ins_pc    = r_ins_pc;
  assign ins_valid = r_ins_valid;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  // Saturating counters; flush deliberately does not clear them.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_fetch_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else begin
      if (w_handshake && (r_fetch_count != 32'hFFFF_FFFF))
        r_fetch_count <= r_fetch_count + 32'd1;
      if ((r_state == REQ) && !imem_ack && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives transaction-level fetches (pc, wait states, read data, decode
// backpressure, optional flush point) and checks every cycle of each one
// against the expected fetch behaviour. Inputs change just after the falling
// edge; outputs are sampled on the falling edge, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstd;
  logic [31:0] pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] pc_plus4;
  logic        busy;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Reference model state: last captured word/address and expected counts.
  logic [31:0] last_ins;
  logic [31:0] last_pc;
  int unsigned exp_fetch;
  int unsigned exp_stall;

  fetch_unit #(.RESET_ADDR(RESET_ADDR)) dut (
    .clk         (clk),
    .rstd        (rstd),
    .pc          (pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .pc_plus4    (pc_plus4),
    .busy        (busy),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // One fetch, starting and (normally) ending at a falling edge in IDLE.
  // fl: 0 = no flush, 1 = flush together with the ack, 2 = flush during HOLD.
  task automatic do_fetch(input logic [31:0] p, input int waits,
                          input logic [31:0] d, input int bp, input int fl);
    logic [31:0] exp_addr;
    exp_addr   = p & 32'hFFFF_FFFC;
    pc         = p;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    ins_ready  = 1'b0;
    imem_rdata = $urandom;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, ins_valid, busy} !== {1'b1, exp_addr, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL req_issue: got req=%b addr=%h valid=%b busy=%b want req=1 addr=%h valid=0 busy=1",
               imem_req, imem_addr, ins_valid, busy, exp_addr);
    end
    for (int w = 0; w < waits; w++) begin
      pc         = $urandom;   // must not be resampled outside IDLE
      imem_rdata = $urandom;
      @(negedge clk);
      exp_stall++;
      total++;
      if ({imem_req, imem_addr, ins_valid, busy} !== {1'b1, exp_addr, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL req_hold[%0d]: got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                 w, imem_req, imem_addr, ins_valid, exp_addr);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = d;
    flush      = (fl == 1);
    @(negedge clk);
    imem_ack   = 1'b0;
    flush      = 1'b0;
    imem_rdata = $urandom;
    if (fl == 1) begin
      total++;
      if ({imem_req, ins_valid, busy, ins, ins_pc} !== {1'b0, 1'b0, 1'b0, last_ins, last_pc}) begin
        bad++;
        $display("FAIL flush_ack: got req=%b valid=%b busy=%b ins=%h ins_pc=%h want 0 0 0 %h %h",
                 imem_req, ins_valid, busy, ins, ins_pc, last_ins, last_pc);
      end
      return;
    end
    last_ins = d;
    last_pc  = exp_addr;
    total++;
    if ({imem_req, ins_valid, busy, ins, ins_pc, pc_plus4} !==
        {1'b0, 1'b1, 1'b1, d, exp_addr, exp_addr + 32'd4}) begin
      bad++;
      $display("FAIL capture: got req=%b valid=%b busy=%b ins=%h ins_pc=%h pc_plus4=%h want 0 1 1 %h %h %h",
               imem_req, ins_valid, busy, ins, ins_pc, pc_plus4, d, exp_addr, exp_addr + 32'd4);
    end
    for (int b = 0; b < bp; b++) begin
      imem_ack   = 1'($urandom_range(0, 1));  // stray acks must be ignored
      imem_rdata = $urandom;
      @(negedge clk);
      total++;
      if ({imem_req, ins_valid, busy, ins, ins_pc} !== {1'b0, 1'b1, 1'b1, d, exp_addr}) begin
        bad++;
        $display("FAIL backpressure[%0d]: got req=%b valid=%b ins=%h ins_pc=%h want 0 1 %h %h",
                 b, imem_req, ins_valid, ins, ins_pc, d, exp_addr);
      end
    end
    imem_ack = 1'b0;
    if (fl == 2) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++;
      if ({imem_req, ins_valid, busy, ins, ins_pc} !== {1'b0, 1'b0, 1'b0, d, exp_addr}) begin
        bad++;
        $display("FAIL flush_hold: got req=%b valid=%b busy=%b ins=%h ins_pc=%h want 0 0 0 %h %h",
                 imem_req, ins_valid, busy, ins, ins_pc, d, exp_addr);
      end
      return;
    end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    exp_fetch++;
    total++;
    if ({imem_req, ins_valid, busy} !== {1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL accept: got req=%b valid=%b busy=%b want 0 0 0", imem_req, ins_valid, busy);
    end
  endtask

  task automatic test_reset();
    rstd       = 1'b0;
    pc         = 32'h0;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    ins_ready  = 1'b0;
    last_ins   = 32'h0;
    last_pc    = RESET_ADDR;
    exp_fetch  = 0;
    exp_stall  = 0;
    #22;
    total++;
    if ({imem_req, ins_valid, busy, imem_addr, ins_pc, ins, fetch_count, stall_count} !==
        {1'b0, 1'b0, 1'b0, RESET_ADDR, RESET_ADDR, 32'h0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_values: got req=%b valid=%b busy=%b addr=%h ins_pc=%h ins=%h fc=%h sc=%h want all zero",
               imem_req, ins_valid, busy, imem_addr, ins_pc, ins, fetch_count, stall_count);
    end
    @(negedge clk);
    rstd = 1'b1;
  endtask

  task automatic test_basic();
    do_fetch(32'h0000_0000, 0, 32'h1234_5678, 0, 0);
  endtask

  task automatic test_wait_states();
    do_fetch(32'h0000_1000, 3, 32'hCAFE_0001, 0, 0);
  endtask

  task automatic test_backpressure();
    do_fetch(32'h0000_2004, 1, 32'hBEEF_0002, 4, 0);
  endtask

  task automatic test_flush();
    // Flush in IDLE keeps the unit idle.
    pc    = 32'h0000_3000;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if ({imem_req, ins_valid, busy} !== {1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL flush_idle: got req=%b valid=%b busy=%b want 0 0 0", imem_req, ins_valid, busy);
    end
    do_fetch(32'h0000_4000, 2, 32'h8765_4321, 0, 1);
    do_fetch(32'h0000_5008, 0, 32'h0BAD_F00D, 0, 0);   // new pc after flush
    do_fetch(32'h0000_6000, 0, 32'h1111_2222, 2, 2);
  endtask

  task automatic test_boundary();
    do_fetch(32'hFFFF_FFFC, 0, 32'hA5A5_A5A5, 0, 0);
    do_fetch(32'h8765_4321, 1, 32'h5A5A_5A5A, 0, 0);
  endtask

  task automatic test_async_reset();
    pc = 32'hABCD_0004;
    @(negedge clk);
    #2 rstd = 1'b0;
    #1;
    last_ins  = 32'h0;
    last_pc   = RESET_ADDR;
    exp_fetch = 0;
    exp_stall = 0;
    total++;
    if ({imem_req, ins_valid, busy, imem_addr, ins_pc, ins, fetch_count, stall_count} !==
        {1'b0, 1'b0, 1'b0, RESET_ADDR, RESET_ADDR, 32'h0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL async_reset: got req=%b valid=%b busy=%b addr=%h ins_pc=%h ins=%h want reset values",
               imem_req, ins_valid, busy, imem_addr, ins_pc, ins);
    end
    @(negedge clk);
    rstd = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_fetch($urandom, int'($urandom_range(0, 4)), $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 5) < 4 ? 0 : $urandom_range(1, 2)));
    end
  endtask

  task automatic test_counters();
`ifdef FETCH_STATS_EN
    total++;
    if ({fetch_count, stall_count} !== {exp_fetch, exp_stall}) begin
      bad++;
      $display("FAIL counters: got fetch=%0d stall=%0d want fetch=%0d stall=%0d",
               fetch_count, stall_count, exp_fetch, exp_stall);
    end
`else
    total++;
    if ({fetch_count, stall_count} !== 64'h0) begin
      bad++;
      $display("FAIL counters_tied: got fetch=%h stall=%h want 0 0", fetch_count, stall_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_backpressure();
    test_flush();
    test_boundary();
    test_counters();
    test_async_reset();
    test_random();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
